// File: rtl/cmul_pkg.sv
`timescale 1ns/1ps
// Shared types and helpers for the complex-multiplier arbiter slice.
package cmul_pkg;

  // Default component width; a product or operand word holds four components.
  localparam int DEF_WIDTH = 16;

  // Largest requester count the round-robin search is written for.
  localparam int MAX_PORTS = 16;

  // Operand/product word at the default component width.
  typedef logic [4*DEF_WIDTH-1:0] cmul_word_t;

  // Width of a requester tag: ceil(log2(num_ports)), never below 1.
  function automatic int tag_width(input int num_ports);
    return (num_ports > 2) ? $clog2(num_ports) : 1;
  endfunction

  // Round-robin search: first valid index at or after ptr, wrapping at
  // num_ports. Returns ptr unchanged when nothing is valid.
  function automatic logic [3:0] rr_next(input logic [MAX_PORTS-1:0] valid,
                                         input logic [3:0]           ptr,
                                         input int                   num_ports);
    logic [3:0] sel;
    logic       found;
    int         idx;
    sel   = ptr;
    found = 1'b0;
    for (int k = 0; k < MAX_PORTS; k++) begin
      idx = int'(ptr) + k;
      if (idx >= num_ports) begin
        idx = idx - num_ports;
      end else begin
        idx = idx;
      end
      if ((k < num_ports) && !found && valid[idx[3:0]]) begin
        sel   = idx[3:0];
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/cmul_if.sv
`timescale 1ns/1ps
// Bundle of requester, multiplier and product-return streams around the arbiter.
interface cmul_if #(
  parameter int WIDTH     = 16,
  parameter int NUM_PORTS = 4
);
  // Requester operand streams
  logic [NUM_PORTS-1:0]         s_valid;
  logic [NUM_PORTS-1:0]         s_ready;
  logic [NUM_PORTS*4*WIDTH-1:0] s_data;
  // Operand stream into the multiplier
  logic                         c_valid;
  logic                         c_ready;
  logic [4*WIDTH-1:0]           c_data;
  // Product stream out of the multiplier
  logic                         r_valid;
  logic                         r_ready;
  logic [4*WIDTH-1:0]           r_data;
  // Per-requester product delivery
  logic [NUM_PORTS-1:0]         m_valid;
  logic [NUM_PORTS-1:0]         m_ready;
  logic [4*WIDTH-1:0]           m_data;
  // Sticky protocol error
  logic                         err;

  // Environment side: requesters, multiplier and consumers
  modport master (
    output s_valid, s_data, c_ready, r_valid, r_data, m_ready,
    input  s_ready, c_valid, c_data, r_ready, m_valid, m_data, err
  );

  // Arbiter side
  modport slave (
    input  s_valid, s_data, c_ready, r_valid, r_data, m_ready,
    output s_ready, c_valid, c_data, r_ready, m_valid, m_data, err
  );
endinterface

// File: rtl/cmul_arbiter_tag_fifo.sv
`timescale 1ns/1ps
// In-order FIFO of requester tags, one entry per product in flight.
module tag_fifo #(
  parameter int DEPTH     = 4,
  parameter int TAG_WIDTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [TAG_WIDTH-1:0]       push_data,
  input  logic                       pop,
  output logic [TAG_WIDTH-1:0]       head,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  import cmul_pkg::*;

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [TAG_WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_r;
  logic [PTR_W-1:0]     rd_ptr_r;
  logic [CNT_W-1:0]     count_r;
  logic                 push_ok_s;
  logic                 pop_ok_s;

  // Pointer increment that wraps at DEPTH (DEPTH need not be a power of two).
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty     = (count_r == '0);
  assign full      = (count_r == CNT_W'(DEPTH));
  assign count     = count_r;
  assign head      = mem_r[rd_ptr_r];
  // Overflow/underflow requests are dropped rather than corrupting state.
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;

  // Storage, pointers and occupancy; simultaneous push and pop keep the count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= ptr_inc(wr_ptr_r);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/cmul_arbiter.sv
`timescale 1ns/1ps
// Round-robin sharing of one pipelined complex multiplier among NUM_PORTS
// requesters, with an in-order tag FIFO steering each product back home.
module cmul_arbiter
  import cmul_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int NUM_PORTS = 4,
  parameter int DEPTH     = 4
) (
  input logic   clk,
  input logic   reset,
  cmul_if.slave bus
);

  localparam int TAG_W = tag_width(NUM_PORTS);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int WW    = 4 * WIDTH;

  typedef logic [WW-1:0] word_t;

  logic [TAG_W-1:0]     rr_ptr_r;
  logic [TAG_W-1:0]     lock_idx_r;
  logic                 lock_r;
  logic                 err_r;
  logic                 issue_en_r;

  logic [MAX_PORTS-1:0] valid_ext_s;
  logic [TAG_W-1:0]     grant_s;
  logic [TAG_W-1:0]     ptr_next_s;
  logic [TAG_W-1:0]     head_s;
  logic [CNT_W-1:0]     count_s;
  logic                 any_valid_s;
  logic                 issue_ok_s;
  logic                 c_valid_s;
  logic                 push_s;
  logic                 pop_s;
  logic                 empty_s;
  logic                 full_s;
  logic                 r_ready_s;
  word_t                c_data_s;
  logic [NUM_PORTS-1:0] s_ready_s;
  logic [NUM_PORTS-1:0] m_valid_s;

  // Widen the request vector to the fixed width the search helper expects.
  always_comb begin
    valid_ext_s                = '0;
    valid_ext_s[NUM_PORTS-1:0] = bus.s_valid;
  end

  // A stalled transfer keeps its grant so c_data cannot change under the multiplier.
  assign grant_s     = lock_r ? lock_idx_r
                              : TAG_W'(rr_next(valid_ext_s, 4'(rr_ptr_r), NUM_PORTS));
  assign ptr_next_s  = (grant_s == TAG_W'(NUM_PORTS - 1)) ? '0 : grant_s + TAG_W'(1);
  assign any_valid_s = |bus.s_valid;
  // No push/pop bypass: a full FIFO blocks issue even on a popping cycle.
  // issue_en_r keeps the operand side quiet for the first cycle after reset.
  assign issue_ok_s  = issue_en_r && !full_s && (count_s < CNT_W'(DEPTH));
  assign c_valid_s   = any_valid_s && issue_ok_s;
  assign push_s      = c_valid_s && bus.c_ready;
  assign pop_s       = bus.r_valid && r_ready_s;

  // Operand mux and ready steering toward the granted requester only.
  always_comb begin
    c_data_s  = '0;
    s_ready_s = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant_s == TAG_W'(i)) begin
        c_data_s     = bus.s_data[i*WW +: WW];
        s_ready_s[i] = bus.c_ready && issue_ok_s;
      end else begin
        s_ready_s[i] = 1'b0;
      end
    end
  end

  // Product steering: the head tag owns the multiplier output this cycle.
  always_comb begin
    m_valid_s = '0;
    r_ready_s = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!empty_s && (head_s == TAG_W'(i))) begin
        m_valid_s[i] = bus.r_valid;
        r_ready_s    = bus.m_ready[i];
      end else begin
        m_valid_s[i] = 1'b0;
      end
    end
  end

  // Arbitration state, reset-release enable and sticky error flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr_r   <= '0;
      lock_idx_r <= '0;
      lock_r     <= 1'b0;
      err_r      <= 1'b0;
      issue_en_r <= 1'b0;
    end else begin
      issue_en_r <= 1'b1;
      if (push_s) begin
        rr_ptr_r <= ptr_next_s;
        lock_r   <= 1'b0;
      end else if (c_valid_s && !bus.c_ready) begin
        lock_r     <= 1'b1;
        lock_idx_r <= grant_s;
      end else begin
        lock_r <= lock_r;
      end
      // A product with no outstanding tag has no owner.
      if (bus.r_valid && empty_s) begin
        err_r <= 1'b1;
      end
    end
  end

  tag_fifo #(
    .DEPTH     (DEPTH),
    .TAG_WIDTH (TAG_W)
  ) u_tag_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_s),
    .push_data (grant_s),
    .pop       (pop_s),
    .head      (head_s),
    .empty     (empty_s),
    .full      (full_s),
    .count     (count_s)
  );

  assign bus.c_valid = c_valid_s;
  assign bus.c_data  = c_data_s;
  assign bus.s_ready = s_ready_s;
  assign bus.m_valid = m_valid_s;
  assign bus.r_ready = r_ready_s;
  assign bus.m_data  = bus.r_data;
  assign bus.err     = err_r;

endmodule

// File: tb/tb_cmul_arbiter.sv
`timescale 1ns/1ps
// Directed bench for cmul_arbiter with a latency-3 multiplier model that has
// an output buffer, so tag-FIFO limits can be reached before the multiplier stalls.
module tb_cmul_arbiter;
  import cmul_pkg::*;

  localparam int WIDTH     = 16;
  localparam int NUM_PORTS = 4;
  localparam int DEPTH     = 4;

  logic clk;
  logic reset;
  logic hold;
  logic spur;
  int   n_assert;
  int   n_fail;

  cmul_if #(.WIDTH(WIDTH), .NUM_PORTS(NUM_PORTS)) bus ();

  cmul_arbiter #(.WIDTH(WIDTH), .NUM_PORTS(NUM_PORTS), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Operand word: a = (p+1) + j*c, b = 3 - 2j.
  function automatic cmul_word_t opw(input int p, input int c);
    logic [15:0] ar, ai;
    ar = 16'(p + 1);
    ai = 16'(c);
    return {ar, ai, 16'h0003, 16'hFFFE};
  endfunction

  // Complex product as 32-bit signed {re, im}.
  function automatic cmul_word_t cmul(input cmul_word_t w);
    logic signed [31:0] ar, ai, br, bi, re, im;
    ar = {{16{w[63]}}, w[63:48]};
    ai = {{16{w[47]}}, w[47:32]};
    br = {{16{w[31]}}, w[31:16]};
    bi = {{16{w[15]}}, w[15:0]};
    re = ar * br - ai * bi;
    im = ar * bi + ai * br;
    return {re, im};
  endfunction

  // ---------------- multiplier model ----------------
  logic [2:0]  pv_r;
  cmul_word_t  pd_r [3];
  cmul_word_t  qb_r [8];
  logic [2:0]  qrd_r;
  logic [3:0]  qcnt_r;
  logic        mdl_pop_s, pop_q_s, pop_pipe_s, push_q_s, acc_s;
  logic [2:0]  qwa_s;

  always_comb begin
    mdl_pop_s  = bus.r_valid && bus.r_ready;
    pop_q_s    = mdl_pop_s && (qcnt_r != 4'd0);
    pop_pipe_s = mdl_pop_s && (qcnt_r == 4'd0);
    push_q_s   = pv_r[2] && !pop_pipe_s;
    acc_s      = bus.c_valid && bus.c_ready;
    qwa_s      = qrd_r + qcnt_r[2:0];
  end

  assign bus.r_valid = (qcnt_r != 4'd0) || pv_r[2] || spur;
  assign bus.r_data  = (qcnt_r != 4'd0) ? qb_r[qrd_r] : pd_r[2];
  assign bus.c_ready = !hold &&
                       ((qcnt_r + {3'd0, pv_r[0]} + {3'd0, pv_r[1]} + {3'd0, pv_r[2]}) < 4'd8);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pv_r   <= 3'd0;
      qrd_r  <= 3'd0;
      qcnt_r <= 4'd0;
    end else begin
      pv_r    <= {pv_r[1:0], acc_s};
      pd_r[0] <= cmul(bus.c_data);
      pd_r[1] <= pd_r[0];
      pd_r[2] <= pd_r[1];
      if (push_q_s) qb_r[qwa_s] <= pd_r[2];
      if (pop_q_s) qrd_r <= qrd_r + 3'd1;
      qcnt_r <= qcnt_r + {3'd0, push_q_s} - {3'd0, pop_q_s};
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic [3:0] v, input int tagc);
    bus.s_valid = v;
    for (int p = 0; p < NUM_PORTS; p++) bus.s_data[p*64 +: 64] = opw(p, tagc);
  endtask

  function automatic logic [3:0] oh(input int g);
    logic [3:0] one;
    one = 4'b0001;
    return one << g;
  endfunction

  // Watchdog: the sequence below is bounded, this only guards against a hang.
  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    n_assert = 0;
    n_fail   = 0;
    hold     = 1'b0;
    spur     = 1'b0;
    reset    = 1'b0;
    bus.m_ready = 4'b1111;
    drive(4'b1111, 0);

    // Reset state, with requests already pending.
    #3;
    chk("rst_s_ready", 64'(bus.s_ready), 64'd0);
    chk("rst_c_valid", 64'(bus.c_valid), 64'd0);
    chk("rst_r_ready", 64'(bus.r_ready), 64'd0);
    chk("rst_m_valid", 64'(bus.m_valid), 64'd0);
    chk("rst_err",     64'(bus.err),     64'd0);
    tick();
    reset = 1'b1;
    #1;
    chk("post_rst_c_valid", 64'(bus.c_valid), 64'd0);
    chk("post_rst_s_ready", 64'(bus.s_ready), 64'd0);
    drive(4'b0000, 0);

    // Single requester: port 2, three back-to-back operands.
    for (int c = 0; c < 8; c++) begin
      tick();
      if (c < 3) drive(4'b0100, c); else drive(4'b0000, 0);
      #1;
      if (c < 3) begin
        chk("t1_c_valid", 64'(bus.c_valid), 64'd1);
        chk("t1_c_data",  bus.c_data,       opw(2, c));
        chk("t1_s_ready", 64'(bus.s_ready), 64'(4'b0100));
      end
      if (c == 0) chk("t1_c_data_lit", bus.c_data, 64'h0003_0000_0003_FFFE);
      chk("t1_m_valid", 64'(bus.m_valid), (c >= 3 && c <= 5) ? 64'(4'b0100) : 64'd0);
      if (c >= 3 && c <= 5) chk("t1_m_data", bus.m_data, cmul(opw(2, c - 3)));
      if (c == 3) chk("t1_m_data_lit", bus.m_data, 64'h0000_0009_FFFF_FFFA);
    end

    // All ports valid: pointer sits at 3 after port 2, so order is 3,0,1,2,...
    for (int c = 0; c < 15; c++) begin
      tick();
      if (c < 12) drive(4'b1111, 16 + c); else drive(4'b0000, 0);
      #1;
      if (c < 12) begin
        chk("t2_s_ready", 64'(bus.s_ready), 64'(oh((3 + c) % 4)));
        chk("t2_c_data",  bus.c_data,       opw((3 + c) % 4, 16 + c));
      end else begin
        chk("t2_idle_c_valid", 64'(bus.c_valid), 64'd0);
      end
      if (c >= 3) begin
        chk("t2_m_valid", 64'(bus.m_valid), 64'(oh(c % 4)));
        chk("t2_m_data",  bus.m_data,       cmul(opw(c % 4, 16 + c - 3)));
      end else begin
        chk("t2_m_valid_lead", 64'(bus.m_valid), 64'd0);
      end
    end

    // One port-0 transfer moves the pointer to 1.
    for (int c = 0; c < 5; c++) begin
      tick();
      if (c == 0) drive(4'b0001, 40); else drive(4'b0000, 0);
      #1;
      if (c == 0) chk("p0_s_ready", 64'(bus.s_ready), 64'(4'b0001));
      chk("p0_m_valid", 64'(bus.m_valid), (c == 3) ? 64'(4'b0001) : 64'd0);
    end

    // Lock: port 1 stalled 5 cycles, port 0 joins in cycle 2.
    for (int c = 0; c < 11; c++) begin
      tick();
      hold = (c < 5);
      if (c < 2)       drive(4'b0010, 50);
      else if (c < 6)  drive(4'b0011, 50);
      else if (c == 6) drive(4'b0001, 50);
      else             drive(4'b0000, 0);
      #1;
      if (c < 5) begin
        chk("lk_c_data",  bus.c_data,       opw(1, 50));
        chk("lk_s_ready", 64'(bus.s_ready), 64'd0);
      end
      if (c == 5) chk("lk_first",  64'(bus.s_ready), 64'(4'b0010));
      if (c == 6) chk("lk_second", 64'(bus.s_ready), 64'(4'b0001));
      chk("lk_m_valid", 64'(bus.m_valid),
          (c == 8) ? 64'(4'b0010) : (c == 9) ? 64'(4'b0001) : 64'd0);
    end

    // Lock against the pointer: locked to port 0 while pointer favours port 1.
    for (int c = 0; c < 8; c++) begin
      tick();
      hold = (c < 2);
      if (c == 0)     drive(4'b0001, 60);
      else if (c < 3) drive(4'b0011, 60);
      else if (c == 3) drive(4'b0010, 60);
      else            drive(4'b0000, 0);
      #1;
      if (c < 3) chk("lk2_c_data", bus.c_data, opw(0, 60));
      if (c == 1) chk("lk2_s_ready_stall", 64'(bus.s_ready), 64'd0);
      if (c == 2) chk("lk2_first",  64'(bus.s_ready), 64'(4'b0001));
      if (c == 3) chk("lk2_second", 64'(bus.s_ready), 64'(4'b0010));
      chk("lk2_m_valid", 64'(bus.m_valid),
          (c == 5) ? 64'(4'b0001) : (c == 6) ? 64'(4'b0010) : 64'd0);
    end

    // Full tag FIFO: port 3 streams while its consumer is not ready.
    for (int c = 0; c < 12; c++) begin
      tick();
      bus.m_ready = (c < 6) ? 4'b0111 : 4'b1111;
      if (c < 8) drive(4'b1000, 70 + c); else drive(4'b0000, 0);
      #1;
      if (c < 4 || c == 7) begin
        chk("ff_c_valid", 64'(bus.c_valid), 64'd1);
        chk("ff_s_ready", 64'(bus.s_ready), 64'(4'b1000));
      end else if (c < 7) begin
        chk("ff_blk_c_valid", 64'(bus.c_valid), 64'd0);
        chk("ff_blk_s_ready", 64'(bus.s_ready), 64'd0);
      end
      chk("ff_m_valid", 64'(bus.m_valid), (c >= 3 && c <= 10) ? 64'(4'b1000) : 64'd0);
      if (c >= 3 && c <= 10) begin
        chk("ff_r_ready", 64'(bus.r_ready), (c >= 6) ? 64'd1 : 64'd0);
        chk("ff_m_data", bus.m_data,
            cmul(opw(3, (c <= 6) ? 70 : (c <= 9) ? 70 + c - 6 : 77)));
      end
    end

    // Output backpressure: head tag 3 held for 6 cycles.
    for (int c = 0; c < 12; c++) begin
      tick();
      bus.m_ready = (c < 9) ? 4'b0111 : 4'b1111;
      if (c == 0) drive(4'b1000, 80); else drive(4'b0000, 0);
      #1;
      if (c >= 3 && c <= 8) begin
        chk("bp_r_ready", 64'(bus.r_ready), 64'd0);
        chk("bp_m_valid", 64'(bus.m_valid), 64'(4'b1000));
        chk("bp_m_data",  bus.m_data,       cmul(opw(3, 80)));
      end
      if (c == 9) begin
        chk("bp_rel_r_ready", 64'(bus.r_ready), 64'd1);
        chk("bp_rel_m_valid", 64'(bus.m_valid), 64'(4'b1000));
      end
      if (c >= 10) chk("bp_once", 64'(bus.m_valid), 64'd0);
    end

    // Spurious product with nothing outstanding.
    tick();
    spur = 1'b1;
    #1;
    chk("sp_r_ready", 64'(bus.r_ready), 64'd0);
    chk("sp_m_valid", 64'(bus.m_valid), 64'd0);
    chk("sp_err_pre", 64'(bus.err),     64'd0);
    for (int c = 0; c < 3; c++) begin
      tick();
      spur = 1'b0;
      #1;
      chk("sp_err_sticky", 64'(bus.err), 64'd1);
    end

    // Reset mid-traffic with two products in flight and a lock on port 3.
    for (int c = 0; c < 3; c++) begin
      tick();
      hold = (c == 2);
      drive(4'b1000, 90 + c);
      #1;
    end
    chk("mr_locked_s_ready", 64'(bus.s_ready), 64'd0);
    reset = 1'b0;
    #1;
    chk("mr_err",     64'(bus.err),     64'd0);
    chk("mr_c_valid", 64'(bus.c_valid), 64'd0);
    chk("mr_s_ready", 64'(bus.s_ready), 64'd0);
    chk("mr_r_ready", 64'(bus.r_ready), 64'd0);
    chk("mr_m_valid", 64'(bus.m_valid), 64'd0);
    tick();
    hold = 1'b0;
    drive(4'b0000, 0);
    reset = 1'b1;
    #1;
    chk("mr_rel_c_valid", 64'(bus.c_valid), 64'd0);
    for (int c = 0; c < 6; c++) begin
      tick();
      #1;
      chk("mr_no_m_valid", 64'(bus.m_valid), 64'd0);
      chk("mr_no_err",     64'(bus.err),     64'd0);
    end
    // Pointer back at 0 and lock gone: ports 1 and 2 request, port 1 wins.
    for (int c = 0; c < 5; c++) begin
      tick();
      if (c == 0) drive(4'b0110, 95); else drive(4'b0000, 0);
      #1;
      if (c == 0) begin
        chk("mr_ptr_s_ready", 64'(bus.s_ready), 64'(4'b0010));
        chk("mr_ptr_c_data",  bus.c_data,       opw(1, 95));
      end
      chk("mr_ptr_m_valid", 64'(bus.m_valid), (c == 3) ? 64'(4'b0010) : 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
